ball_controller: RTL and testbench

BALL_CONTROLLER -- requirements
Module: ball_controller

---
 rtl/game_params_pkg.sv | 24 ++
 rtl/tick_gen.sv | 29 ++
 rtl/ball_controller.sv | 160 ++++++++++++++++
 tb/tb_ball_controller.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_params_pkg.sv
// rtl/game_params_pkg.sv - shared playfield, paddle and direction definitions
// Used by the ball and player controllers so both agree on geometry.
package game_params_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int PADDLE_W = 32;
  localparam int PADDLE_H = 16;

  localparam logic [9:0] BALL_RESET_X = 10'd316;
  localparam logic [9:0] BALL_RESET_Y = 10'd452;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

  typedef enum logic [1:0] {
    BALL_HELD   = 2'd0,
    BALL_MOVING = 2'd1,
    BALL_LOST   = 2'd2
  } ball_state_t;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running divider producing a one-cycle motion tick
// Counter is held at zero while disabled, so enabling restarts a full period.
module tick_gen #(
  parameter int TICK_DIV = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!enable || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/ball_controller.sv
// rtl/ball_controller.sv - ball serve, motion, wall/paddle reflection and loss
// Positions are widened to 11 bits for every comparison so no sum can wrap.
module ball_controller
  import game_params_pkg::*;
#(
  parameter int BALL_SIZE  = 8,
  parameter int STEP       = 2,
  parameter int TICK_DIV   = 250000,
  parameter int LOST_TICKS = 100
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       launch_button,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_active,
  output logic       miss
);

  localparam logic [10:0] BS     = 11'(BALL_SIZE);
  localparam logic [10:0] ST     = 11'(STEP);
  localparam logic [10:0] PW     = 11'(PADDLE_W);
  localparam logic [10:0] CENTER = 11'(PADDLE_W / 2 - BALL_SIZE / 2);
  localparam logic [10:0] X_MAX  = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [10:0] Y_LOSS = 11'(SCREEN_H - BALL_SIZE);
  localparam int LCW = (LOST_TICKS > 1) ? $clog2(LOST_TICKS) : 1;
  localparam logic [LCW-1:0] LOST_LAST = LCW'(LOST_TICKS - 1);

  ball_state_t    state, state_d;
  dir_t           dx, dx_d, dy, dy_d;
  logic [9:0]     bx_d, by_d;
  logic [LCW-1:0] lost_cnt, lost_cnt_d;
  logic           miss_d;
  logic [2:0]     sync_q;
  logic           launch_evt;
  logic           tick;
  logic           paddle_hit;
  logic [10:0]    bx11, by11, px11, py11;

  // sync_q[1:0] is the 2-FF synchronizer; sync_q[2] remembers the previous level
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) sync_q <= 3'b111;
    else       sync_q <= {sync_q[1:0], launch_button};
  end
  assign launch_evt = sync_q[2] && !sync_q[1];

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk    (CLOCK_50),
    .reset  (reset),
    .enable (state != BALL_HELD),
    .tick   (tick)
  );

  assign bx11 = {1'b0, ball_x};
  assign by11 = {1'b0, ball_y};
  assign px11 = {1'b0, player_x};
  assign py11 = {1'b0, player_y};

  assign paddle_hit = (dy == DIR_POS)
                   && (by11 + BS <= py11)
                   && (by11 + BS + ST >= py11)
                   && (bx11 + BS > px11)
                   && (bx11 < px11 + PW);

  always_comb begin
    state_d    = state;
    bx_d       = ball_x;
    by_d       = ball_y;
    dx_d       = dx;
    dy_d       = dy;
    lost_cnt_d = lost_cnt;
    miss_d     = 1'b0;
    case (state)
      BALL_HELD: begin
        bx_d = 10'(px11 + CENTER);
        by_d = 10'(py11 - BS);
        if (launch_evt) begin
          state_d = BALL_MOVING;
          dx_d    = DIR_POS;
          dy_d    = DIR_NEG;
        end
      end
      BALL_MOVING: begin
        if (tick) begin
          if (dx == DIR_POS) begin
            if (bx11 + ST > X_MAX) begin
              bx_d = 10'(X_MAX);
              dx_d = DIR_NEG;
            end else begin
              bx_d = 10'(bx11 + ST);
            end
          end else if (bx11 < ST) begin
            bx_d = '0;
            dx_d = DIR_POS;
          end else begin
            bx_d = 10'(bx11 - ST);
          end

          if (dy == DIR_NEG) begin
            if (by11 < ST) begin
              by_d = '0;
              dy_d = DIR_POS;
            end else begin
              by_d = 10'(by11 - ST);
            end
          end else if (paddle_hit) begin
            by_d = 10'(py11 - BS);
            dy_d = DIR_NEG;
          end else if (by11 + ST >= Y_LOSS) begin
            // the ball freezes where it fell through
            state_d = BALL_LOST;
            miss_d  = 1'b1;
            bx_d    = ball_x;
            by_d    = ball_y;
          end else begin
            by_d = 10'(by11 + ST);
          end
        end
      end
      BALL_LOST: begin
        if (tick) begin
          if (lost_cnt == LOST_LAST) begin
            state_d    = BALL_HELD;
            lost_cnt_d = '0;
            dx_d       = DIR_POS;
            dy_d       = DIR_NEG;
          end else begin
            lost_cnt_d = lost_cnt + LCW'(1);
          end
        end
      end
      default: state_d = BALL_HELD;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state    <= BALL_HELD;
      ball_x   <= BALL_RESET_X;
      ball_y   <= BALL_RESET_Y;
      dx       <= DIR_POS;
      dy       <= DIR_NEG;
      lost_cnt <= '0;
      miss     <= 1'b0;
    end else begin
      state    <= state_d;
      ball_x   <= bx_d;
      ball_y   <= by_d;
      dx       <= dx_d;
      dy       <= dy_d;
      lost_cnt <= lost_cnt_d;
      miss     <= miss_d;
    end
  end

  assign ball_active = (state != BALL_LOST);

endmodule

// File: tb/tb_ball_controller.sv
// tb/tb_ball_controller.sv - randomized scoreboard bench for ball_controller
module tb_ball_controller;

  localparam int TD = 4;
  localparam int LT = 3;
  localparam int BS = 8;
  localparam int ST = 2;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       launch_button = 1'b1;
  logic [9:0] player_x = 10'd304;
  logic [9:0] player_y = 10'd460;
  logic [9:0] ball_x, ball_y;
  logic       ball_active, miss;

  ball_controller #(.BALL_SIZE(BS), .STEP(ST), .TICK_DIV(TD), .LOST_TICKS(LT)) dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .launch_button (launch_button),
    .player_x      (player_x),
    .player_y      (player_y),
    .ball_x        (ball_x),
    .ball_y        (ball_y),
    .ball_active   (ball_active),
    .miss          (miss)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int x;
    int y;
    bit act;
    bit mis;
  } obs_t;

  obs_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: mode 0 = on paddle, 1 = in flight, 2 = lost
  int     m_mode, m_bx, m_by, m_dx, m_dy, m_mcnt, m_lcnt;
  bit     m_miss;
  bit [2:0] m_hist;
  obs_t   m_prev;

  task automatic model_reset();
    m_mode = 0; m_bx = 316; m_by = 452; m_dx = 1; m_dy = -1;
    m_mcnt = 0; m_lcnt = 0; m_miss = 0; m_hist = 3'b111;
    m_prev = '{0, 316, 452, 1'b1, 1'b0};
  endtask

  task automatic model_edge(input bit btn, input int px, input int py);
    bit ev, hit;
    int nx, ny, ndx, ndy;
    ev = m_hist[2] && !m_hist[1];
    m_hist = {m_hist[1:0], btn};
    m_miss = 0;
    if (m_mode == 0) begin
      m_bx = (px + 16 - BS / 2) & 1023;
      m_by = (py - BS) & 1023;
      if (ev) begin
        m_mode = 1; m_mcnt = 0; m_dx = 1; m_dy = -1;
      end
    end else begin
      m_mcnt++;
      if (m_mcnt % TD == 0) begin
        if (m_mode == 1) begin
          nx = m_bx; ny = m_by; ndx = m_dx; ndy = m_dy;
          if (m_dx > 0) begin
            if (m_bx + ST > 640 - BS) begin nx = 640 - BS; ndx = -1; end
            else nx = m_bx + ST;
          end else begin
            if (m_bx < ST) begin nx = 0; ndx = 1; end
            else nx = m_bx - ST;
          end
          hit = (m_dy > 0) && (m_by + BS <= py) && (m_by + BS + ST >= py)
                && (m_bx + BS > px) && (m_bx < px + 32);
          if (m_dy < 0) begin
            if (m_by < ST) begin ny = 0; ndy = 1; end
            else ny = m_by - ST;
          end else if (hit) begin
            ny = py - BS; ndy = -1;
          end else if (m_by + ST >= 480 - BS) begin
            m_mode = 2; m_lcnt = 0; m_miss = 1; nx = m_bx; ny = m_by;
          end else begin
            ny = m_by + ST;
          end
          m_bx = nx; m_by = ny; m_dx = ndx; m_dy = ndy;
        end else begin
          m_lcnt++;
          if (m_lcnt == LT) begin
            m_mode = 0; m_lcnt = 0; m_dx = 1; m_dy = -1;
          end
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Called at a falling edge; applies inputs, predicts the next rising edge.
  task automatic step(input bit btn, input int px, input int py);
    obs_t o;
    launch_button = btn;
    player_x = 10'(px);
    player_y = 10'(py);
    model_edge(btn, px, py);
    o = '{cyc + 1, m_bx, m_by, (m_mode != 2), m_miss};
    if (o.x != m_prev.x || o.y != m_prev.y || o.act != m_prev.act || o.mis != m_prev.mis)
      exp_q.push_back(o);
    m_prev = o;
    @(negedge CLOCK_50);
  endtask

  task automatic do_reset(input int px, input int py);
    #2;
    launch_button = 1'b1;
    player_x = 10'(px);
    player_y = 10'(py);
    reset = 1'b1;
    #1;
    chk("rst_ball_x", int'(ball_x), 316);
    chk("rst_ball_y", int'(ball_y), 452);
    chk("rst_active", int'(ball_active), 1);
    chk("rst_miss", int'(miss), 0);
    chk("pending_changes", exp_q.size(), 0);
    exp_q.delete();
    model_reset();
    @(negedge CLOCK_50);
    chk("rst_hold_miss", int'(miss), 0);
    @(negedge CLOCK_50);
    reset = 1'b0;
  endtask

  function automatic int pick_x(input int policy, input int px_fixed);
    int v;
    case (policy)
      1: begin
        v = m_bx + 10 - int'($urandom_range(0, 44));
        if (v < 0) v = 0;
        if (v > 600) v = 600;
      end
      2: v = px_fixed;
      default: v = (m_bx >= 320) ? m_bx - 200 : m_bx + 200;
    endcase
    return v;
  endfunction

  // target: 0 run full budget, 1 ball_x moves, 2 ball lost, 3 back on paddle
  task automatic advance(input int policy, input int px_fixed, input int py,
                         input int target, input int budget, input string name);
    int  start_x;
    bit  done;
    bit  btn;
    start_x = m_bx;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      btn = (policy == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      step(btn, pick_x(policy, px_fixed), py);
      case (target)
        1: done = (m_bx != start_x);
        2: done = (m_mode == 2);
        3: done = (m_mode == 0);
        default: done = 0;
      endcase
    end
    if (target != 0 && !done) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic press(input int px, input int py);
    repeat (3) step(1'b0, px, py);
    step(1'b1, px, py);
  endtask

  // Monitor: every change of the DUT outputs consumes one expected observation.
  int lx = 316, ly = 452;
  bit la = 1'b1, lm = 1'b0;
  always @(negedge CLOCK_50) begin
    obs_t e;
    if (reset) begin
      lx = int'(ball_x); ly = int'(ball_y); la = ball_active; lm = miss;
    end else if (int'(ball_x) != lx || int'(ball_y) != ly || ball_active != la || miss != lm) begin
      lx = int'(ball_x); ly = int'(ball_y); la = ball_active; lm = miss;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_change: got x=%0d y=%0d act=%0d miss=%0d at cycle %0d, expected no change",
                 lx, ly, la, lm, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.x != lx || e.y != ly || e.act != la || e.mis != lm) begin
          miscompares++;
          $display("FAIL output_change: got x=%0d y=%0d act=%0d miss=%0d cycle=%0d, expected x=%0d y=%0d act=%0d miss=%0d cycle=%0d",
                   lx, ly, la, lm, cyc, e.x, e.y, e.act, e.mis, e.cyc);
        end
      end
    end
  end

  initial begin
    int py;
    model_reset();
    @(negedge CLOCK_50);
    do_reset(304, 460);
    repeat (3) step(1'b1, 304, 460);

    step(1'b1, 100, 460);
    chk("held_follow_x", int'(ball_x), 112);
    press(100, 460);
    advance(2, 100, 460, 1, 40, "first_tick");
    chk("first_tick_x", int'(ball_x), 114);
    chk("first_tick_y", int'(ball_y), 450);

    do_reset(304, 460);
    repeat (2) step(1'b1, 619, 300);
    chk("held_edge_x", int'(ball_x), 631);
    press(619, 300);
    advance(2, 619, 300, 1, 40, "wall_tick1");
    chk("right_wall_clamp", int'(ball_x), 632);
    advance(2, 619, 300, 1, 40, "wall_tick2");
    chk("right_wall_back", int'(ball_x), 630);

    advance(0, 0, 300, 2, 4000, "loss");
    chk("loss_miss", int'(miss), 1);
    chk("loss_active", int'(ball_active), 0);
    step(1'b1, pick_x(0, 0), 300);
    chk("miss_one_cycle", int'(miss), 0);
    advance(0, 0, 300, 3, 40, "reserve");
    chk("reserve_active", int'(ball_active), 1);
    step(1'b1, 200, 300);
    chk("reserve_on_paddle_x", int'(ball_x), 212);
    chk("reserve_on_paddle_y", int'(ball_y), 292);

    press(200, 300);
    advance(0, 0, 300, 2, 4000, "loss2");
    step(1'b1, pick_x(0, 0), 300);
    do_reset(304, 460);
    repeat (4) step(1'b1, 304, 460);

    for (int r = 0; r < 6; r++) begin
      py = (r == 0) ? 479 : (r == 1) ? 451 : int'($urandom_range(436, 486));
      step(1'b1, int'($urandom_range(0, 600)), py);
      press(int'($urandom_range(0, 600)), py);
      advance(1, 0, py, 0, 2500 + int'($urandom_range(0, 2500)), "rally");
      do_reset(304, 460);
      repeat (3) step(1'b1, 304, 460);
    end

    repeat (5) step(1'b1, 304, 460);
    chk("drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
